syncin_dot2_unit: RTL

Multi-cycle signed fixed-point dot-product unit: result = sat16((a·b + c·d) >>> FRAC_BITS) on four 16-bit operands. It is the responder end of the coprocessor's operation-module handshake. The SyNCiN coprocessor FSM presents operands with an input strobe and collects the result with an output strobe, exactly as it does for its other operation slots. The datapath uses a serial shift-add multiplier, so area stays small at the cost of latency.

---
 rtl/syncin_dot2_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/syncin_dot2_unit.sv
// syncin_dot2_unit: serial fixed-point dot product, sat16((a*b + c*d) >>> FRAC_BITS).
// Responder side of the coprocessor operation handshake.
// One shift-add multiplier is shared by both products, one multiplier bit per cycle.
module syncin_dot2_unit #(
   parameter int FRAC_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] input_a,
   input  logic [15:0] input_b,
   input  logic [15:0] input_c,
   input  logic [15:0] input_d,
   input  logic        dot_input_STB,
   output logic        dot_BUSY,
   output logic [15:0] output_result,
   output logic        dot_output_STB,
   input  logic        output_module_BUSY
);

   typedef enum logic [2:0] {IDLE, MUL_AB, MUL_CD, NORM, DONE} state_t;

   state_t             state_reg, state_next;
   logic [3:0]         cnt_reg;
   logic [15:0]        a_reg, b_reg, c_reg, d_reg;
   logic [31:0]        mag_acc_reg;
   logic signed [31:0] prod_ab_reg, prod_cd_reg;
   logic [15:0]        result_reg;
   logic               busy_reg, ostb_reg;

   logic [16:0]        mcand;
   logic [15:0]        mplier;
   logic [31:0]        addend, mag_sum, signed_prod;
   logic               prod_neg;
   logic signed [32:0] sum33, shifted;
   logic [15:0]        sat_result;

   // 17-bit magnitude so that |-32768| = 32768 is exact.
   function automatic logic [16:0] mag17(input logic [15:0] x);
      return x[15] ? (~{1'b1, x} + 17'd1) : {1'b0, x};
   endfunction

   // Multiplier magnitude: 32768 still fits in 16 unsigned bits (bit 15).
   function automatic logic [15:0] mag16(input logic [15:0] x);
      return x[15] ? (~x + 16'd1) : x;
   endfunction

   // Shared shift-add step, normalisation and saturation.
   always_comb begin
      mcand    = (state_reg == MUL_CD) ? mag17(c_reg) : mag17(a_reg);
      mplier   = (state_reg == MUL_CD) ? mag16(d_reg) : mag16(b_reg);
      prod_neg = (state_reg == MUL_CD) ? (c_reg[15] ^ d_reg[15]) : (a_reg[15] ^ b_reg[15]);
      addend   = 32'd0;
      if (mplier[cnt_reg])
         addend = {15'd0, mcand} << cnt_reg;
      mag_sum     = mag_acc_reg + addend;
      signed_prod = prod_neg ? (32'd0 - mag_sum) : mag_sum;

      sum33   = {prod_ab_reg[31], prod_ab_reg} + {prod_cd_reg[31], prod_cd_reg};
      shifted = sum33 >>> FRAC_BITS;
      if (shifted > 33'sd32767)
         sat_result = 16'h7FFF;
      else if (shifted < -33'sd32768)
         sat_result = 16'h8000;
      else
         sat_result = shifted[15:0];
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (dot_input_STB) state_next = MUL_AB;
         MUL_AB:  if (cnt_reg == 4'd15) state_next = MUL_CD;
         MUL_CD:  if (cnt_reg == 4'd15) state_next = NORM;
         NORM:    state_next = DONE;
         DONE:    if (output_module_BUSY) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Datapath and handshake registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= 4'd0;
         a_reg       <= 16'd0;
         b_reg       <= 16'd0;
         c_reg       <= 16'd0;
         d_reg       <= 16'd0;
         mag_acc_reg <= 32'd0;
         prod_ab_reg <= 32'sd0;
         prod_cd_reg <= 32'sd0;
         result_reg  <= 16'd0;
         busy_reg    <= 1'b0;
         ostb_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (dot_input_STB) begin
                  a_reg       <= input_a;
                  b_reg       <= input_b;
                  c_reg       <= input_c;
                  d_reg       <= input_d;
                  busy_reg    <= 1'b1;
                  cnt_reg     <= 4'd0;
                  mag_acc_reg <= 32'd0;
               end
            end
            MUL_AB, MUL_CD: begin
               cnt_reg <= cnt_reg + 4'd1;
               if (cnt_reg == 4'd15) begin
                  // Last bit: fold the sign in and clear the accumulator for the next product.
                  mag_acc_reg <= 32'd0;
                  if (state_reg == MUL_AB)
                     prod_ab_reg <= signed_prod;
                  else
                     prod_cd_reg <= signed_prod;
               end else begin
                  mag_acc_reg <= mag_sum;
               end
            end
            NORM: begin
               result_reg <= sat_result;
               ostb_reg   <= 1'b1;
            end
            DONE: begin
               if (output_module_BUSY) begin
                  ostb_reg <= 1'b0;
                  busy_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign dot_BUSY       = busy_reg;
   assign dot_output_STB = ostb_reg;
   assign output_result  = result_reg;

endmodule
